// File: rtl/midi_pkg.sv
// Shared constants, parser state type and command-word builder for the MIDI
// note command encoder.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  localparam int CMD_W    = 16;
  localparam int CMD_BIT  = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 8;
  localparam int VEL_MSB  = 7;
  localparam int VEL_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_NOTE = 2'd1,
    WAIT_VEL  = 2'd2
  } parse_state_e;

  // Note-on with velocity 0 is a note-off by MIDI convention; its velocity
  // field is already zero, so only the command bit needs qualifying.
  function automatic logic [CMD_W-1:0] make_word(input logic       is_on,
                                                 input logic [6:0] note,
                                                 input logic [6:0] vel);
    logic [CMD_W-1:0] w;
    w                   = '0;
    w[CMD_BIT]          = is_on && (vel != 7'd0);
    w[NOTE_MSB:NOTE_LSB] = note;
    w[VEL_MSB:VEL_LSB]   = {1'b0, vel};
    return w;
  endfunction

endpackage

// File: rtl/midi_cmd_encoder_sync_fifo.sv
// First-word-fall-through FIFO; head reads zero while empty so the output
// word is clean out of reset.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/midi_cmd_encoder.sv
// MIDI byte stream to 16-bit note command words: running-status Note On/Off
// parser with channel filter, feeding a small output FIFO.
module midi_cmd_encoder
  import midi_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] CHANNEL    = 4'd0,
  parameter bit         OMNI       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic [CMD_W-1:0]  o_data,
  output logic              o_valid,
  input  logic              i_rdy,
  output logic              o_drop
);

  parse_state_e     state_q, state_d;
  logic             is_on_q, is_on_d;
  logic [6:0]       note_q, note_d;
  logic             drop_q, drop_d;
  logic             byte_acc, is_note_status, ch_ok;
  logic             push;
  logic [CMD_W-1:0] push_word;
  logic             fifo_full, fifo_empty;

  // Gating on full means a completing velocity byte always finds room.
  assign o_byte_ready   = !fifo_full && !rst;
  assign byte_acc       = i_byte_valid && o_byte_ready;
  assign is_note_status = (i_byte[7:4] == ST_NOTE_OFF) || (i_byte[7:4] == ST_NOTE_ON);
  assign ch_ok          = OMNI || (i_byte[3:0] == CHANNEL);

  always_comb begin
    state_d   = state_q;
    is_on_d   = is_on_q;
    note_d    = note_q;
    drop_d    = 1'b0;
    push      = 1'b0;
    push_word = make_word(is_on_q, note_q, i_byte[6:0]);
    // Real-time bytes fall through untouched, even mid-message.
    if (byte_acc && (i_byte < RT_MIN)) begin
      if (i_byte[7]) begin
        drop_d = (state_q == WAIT_VEL);
        if (is_note_status && ch_ok) begin
          is_on_d = (i_byte[7:4] == ST_NOTE_ON);
          state_d = WAIT_NOTE;
        end else begin
          is_on_d = 1'b0;
          state_d = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: drop_d = 1'b1;
          WAIT_NOTE: begin
            note_d  = i_byte[6:0];
            state_d = WAIT_VEL;
          end
          WAIT_VEL: begin
            push    = 1'b1;
            state_d = WAIT_NOTE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_on_q <= 1'b0;
      note_q  <= 7'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_on_q <= is_on_d;
      note_q  <= note_d;
      drop_q  <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (i_rdy),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (o_data)
  );

  assign o_valid = !fifo_empty;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_midi_cmd_encoder.sv
// Bench for midi_cmd_encoder: directed vector table, hand-written corner
// sequences and a randomized run against a message-level reference model.
module tb_midi_cmd_encoder;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       i_byte = 8'h00;
  logic             i_byte_valid = 1'b0;
  logic             i_rdy = 1'b0;
  logic [1:0]       rdy, val, drp;
  logic [1:0][15:0] dat;

  always #5 clk = ~clk;

  // dut 0: omni; dut 1: channel 1 only. Both see the same byte stream.
  midi_cmd_encoder #(.FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(rdy[0]), .o_data(dat[0]), .o_valid(val[0]), .i_rdy(i_rdy),
    .o_drop(drp[0]));

  midi_cmd_encoder #(.FIFO_DEPTH(DEPTH), .CHANNEL(4'd1), .OMNI(1'b0)) dut1 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(rdy[1]), .o_data(dat[1]), .o_valid(val[1]), .i_rdy(i_rdy),
    .o_drop(drp[1]));

  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  // Reference model: rs = running status (-1 none, 0 off, 1 on), nt = pending note (-1 none)
  int          rs [2];
  int          nt [2];
  bit          exp_drop [2];
  logic [15:0] expq [2][$];
  logic [15:0] got [2][$];
  int          dcnt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_byte(input int d, input logic [7:0] b,
                            output bit drop, output bit push, output logic [15:0] w);
    bit ch_ok;
    drop = 1'b0; push = 1'b0; w = 16'h0;
    ch_ok = (d == 0) || (b[3:0] == 4'd1);
    if (b >= 8'hF8) return;
    if (b[7]) begin
      if (nt[d] >= 0) drop = 1'b1;
      nt[d] = -1;
      if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && ch_ok) rs[d] = (b[7:4] == 4'h9) ? 1 : 0;
      else rs[d] = -1;
    end else if (rs[d] < 0) begin
      drop = 1'b1;
    end else if (nt[d] < 0) begin
      nt[d] = int'(b);
    end else begin
      push = 1'b1;
      if (rs[d] == 1 && b != 8'h00) w = {1'b1, 7'(nt[d]), b};
      else if (rs[d] == 1)          w = {1'b0, 7'(nt[d]), 8'h00};
      else                          w = {1'b0, 7'(nt[d]), b};
      nt[d] = -1;
    end
  endtask

  // Compare outputs mid-cycle, then advance the model by the coming edge.
  always @(negedge clk) begin
    bit          erdy, dr, ps;
    logic [15:0] w;
    for (int d = 0; d < 2; d++) begin
      erdy = !rst && (expq[d].size() < DEPTH);
      if (mon_en) begin
        check($sformatf("ready%0d", d), rdy[d], erdy);
        check($sformatf("valid%0d", d), val[d], expq[d].size() != 0);
        if (expq[d].size() != 0) check($sformatf("data%0d", d), dat[d], expq[d][0]);
        check($sformatf("drop%0d", d), drp[d], exp_drop[d]);
        if (val[d] && i_rdy && !rst) got[d].push_back(dat[d]);
        if (drp[d]) dcnt[d]++;
      end
      if (rst) begin
        expq[d].delete();
        rs[d] = -1; nt[d] = -1; exp_drop[d] = 1'b0;
      end else begin
        if (expq[d].size() != 0 && i_rdy) void'(expq[d].pop_front());
        exp_drop[d] = 1'b0;
        if (i_byte_valid && erdy) begin
          model_byte(d, i_byte, dr, ps, w);
          exp_drop[d] = dr;
          if (ps) expq[d].push_back(w);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; i_byte_valid = 1'b0; i_rdy = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", rdy[0], 1'b0);
    @(posedge clk); #1;
    check("rst_valid", val[0], 1'b0);
    check("rst_data", dat[0], 16'h0000);
    check("rst_drop", drp[0], 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", rdy[0], 1'b1);
    mon_en = 1'b1;
    got[0].delete(); got[1].delete();
    dcnt[0] = 0; dcnt[1] = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_byte = b; i_byte_valid = 1'b1;
    @(negedge clk);
    while (!rdy[0] && n < 200) begin n++; @(negedge clk); end
    if (!rdy[0]) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%0h ready=%0b required=1", b, rdy[0]);
    end
    @(posedge clk); #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    int          dut;
    int          nb;
    logic [7:0]  b [8];
    int          nw;
    logic [15:0] w [3];
    int          ndrop;
  } vec_t;

  initial begin
    vec_t        tv [6];
    int          r, k;
    logic [15:0] ew;
    for (int d = 0; d < 2; d++) begin rs[d] = -1; nt[d] = -1; exp_drop[d] = 1'b0; dcnt[d] = 0; end

    tv[0] = '{"basic", 0, 3, '{8'h90, 8'h3C, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              1, '{16'hBC64, 16'h0, 16'h0}, 0};
    tv[1] = '{"running", 0, 8, '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00, 8'h80, 8'h3C, 8'h7F},
              3, '{16'hBC64, 16'h4000, 16'h3C7F}, 0};
    tv[2] = '{"realtime", 0, 5, '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64, 8'h00, 8'h00, 8'h00},
              1, '{16'hBC64, 16'h0, 16'h0}, 0};
    tv[3] = '{"stray_data", 0, 1, '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              0, '{16'h0, 16'h0, 16'h0}, 1};
    tv[4] = '{"abandon", 0, 5, '{8'h90, 8'h3C, 8'hB0, 8'h3C, 8'h64, 8'h00, 8'h00, 8'h00},
              0, '{16'h0, 16'h0, 16'h0}, 3};
    tv[5] = '{"chan_filter", 1, 6, '{8'h90, 8'h3C, 8'h64, 8'h91, 8'h3C, 8'h64, 8'h00, 8'h00},
              1, '{16'hBC64, 16'h0, 16'h0}, 2};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int j = 0; j < tv[i].nb; j++) send_byte(tv[i].b[j]);
      idle(6);
      check({tv[i].name, "_nwords"}, got[tv[i].dut].size(), tv[i].nw);
      for (int j = 0; j < tv[i].nw; j++)
        if (j < got[tv[i].dut].size())
          check($sformatf("%s_word%0d", tv[i].name, j), got[tv[i].dut][j], tv[i].w[j]);
      check({tv[i].name, "_drops"}, dcnt[tv[i].dut], tv[i].ndrop);
    end

    // Latency: word visible the cycle after the velocity edge, gone after the pop.
    do_reset();
    send_byte(8'h90); send_byte(8'h3C);
    check("lat_not_early", val[0], 1'b0);
    send_byte(8'h64);
    check("lat_valid", val[0], 1'b1);
    check("lat_data", dat[0], 16'hBC64);
    idle(1);
    check("lat_one_cycle", val[0], 1'b0);

    // Backpressure: four words fill the FIFO, the fifth waits for a pop.
    do_reset();
    i_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h90); send_byte(8'(8'h30 + i)); send_byte(8'(8'h10 + i));
    end
    check("bp_full_ready", rdy[0], 1'b0);
    check("bp_head_valid", val[0], 1'b1);
    check("bp_head_data", dat[0], 16'hB010);
    idle(3);
    check("bp_data_stable", dat[0], 16'hB010);
    i_byte = 8'h90; i_byte_valid = 1'b1;
    i_rdy = 1'b1;
    #1;
    check("bp_ready_not_comb", rdy[0], 1'b0);
    @(posedge clk); #1;
    check("bp_ready_after_pop", rdy[0], 1'b1);
    send_byte(8'h90); send_byte(8'h34); send_byte(8'h14);
    idle(8);
    check("bp_nwords", got[0].size(), 5);
    for (int i = 0; i < 5; i++) begin
      ew = {1'b1, 7'(8'h30 + i), 8'(8'h10 + i)};
      if (i < got[0].size()) check($sformatf("bp_word%0d", i), got[0][i], ew);
    end

    // Randomized run: the negedge monitor compares every cycle against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      rst = (r == 0);
      i_rdy = ($urandom_range(0, 3) != 0);
      i_byte_valid = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 9);
      if (k < 2)       i_byte = {4'h8 | 4'($urandom_range(0, 1)), 4'($urandom_range(0, 2))};
      else if (k == 2) i_byte = 8'($urandom_range(8'hA0, 8'hF7));
      else if (k == 3) i_byte = 8'($urandom_range(8'hF8, 8'hFF));
      else if (k == 4) i_byte = 8'h00;
      else             i_byte = 8'($urandom_range(0, 127));
      @(posedge clk); #1;
    end
    rst = 1'b0; i_byte_valid = 1'b0; i_rdy = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
